// File: rtl/target_q_max_stream_pkg.sv
// Shared FP32 constants and elaboration helpers for the target-Q max/min stream.
package target_q_max_stream_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          FP_SIGN_BIT = 31;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp32_compare.sv
// Combinational sign-magnitude compare of two non-NaN IEEE-754 singles; +0 and -0 are equal.
module fp32_compare
  import target_q_max_stream_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b,
  output logic        a_eq_b
);

  logic        a_s;
  logic        b_s;
  logic [30:0] a_m;
  logic [30:0] b_m;
  logic        both_zero;

  assign a_s       = a[FP_SIGN_BIT];
  assign b_s       = b[FP_SIGN_BIT];
  assign a_m       = a[30:0];
  assign b_m       = b[30:0];
  assign both_zero = (a_m == 31'd0) && (b_m == 31'd0);

  always_comb begin
    a_eq_b = both_zero || (a == b);
    a_gt_b = 1'b0;
    if (!both_zero) begin
      if (a_s != b_s) a_gt_b = !a_s;
      else if (!a_s)  a_gt_b = (a_m > b_m);
      else            a_gt_b = (a_m < b_m);
    end
  end

endmodule

// File: rtl/target_q_result_fifo.sv
// Synchronous result FIFO with combinational head; push and pop may coincide even when full.
module target_q_result_fifo
  import target_q_max_stream_pkg::*;
#(
  parameter int WIDTH = 35,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             has_room
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign valid    = (count != '0);
  assign has_room = (count < CW'(DEPTH));
  assign do_pop   = pop && valid;
  assign do_push  = push && (has_room || do_pop);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/target_q_max_stream.sv
// Streams per-sample Q-values, keeps the running max (or min) and its action index,
// and queues one result per completed group behind valid/ready handshakes.
module target_q_max_stream
  import target_q_max_stream_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int INDEX_WIDTH           = 2,
  parameter int RESULT_FIFO_DEPTH     = 4,
  parameter int SELECT_MIN            = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic                   i_done,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [INDEX_WIDTH-1:0] o_index,
  output logic                   o_terminal
);

  localparam int FW = DATA_WIDTH + INDEX_WIDTH + 1;
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);

  logic                   rdy_en;
  logic [INDEX_WIDTH-1:0] cnt_p0;
  logic [DATA_WIDTH-1:0]  best_p0;
  logic [INDEX_WIDTH-1:0] best_idx_p0;
  logic                   term_p0;

  logic                   has_room;
  logic                   fifo_valid;
  logic [FW-1:0]          fifo_head;
  logic [FW-1:0]          push_data;
  logic                   accept;
  logic                   last_beat;
  logic                   wr_pend;
  logic                   a_gt_b;
  logic                   a_eq_b;
  logic                   better;
  logic [DATA_WIDTH-1:0]  cmp_a;
  logic [DATA_WIDTH-1:0]  cmp_b;
  logic [DATA_WIDTH-1:0]  cand_data;
  logic [INDEX_WIDTH-1:0] cand_idx;

  // For min selection the operands swap, so "better" is always a_gt_b of one comparator.
  assign cmp_a = (SELECT_MIN != 0) ? best_p0 : i_data;
  assign cmp_b = (SELECT_MIN != 0) ? i_data  : best_p0;

  fp32_compare u_cmp (
    .a      (cmp_a),
    .b      (cmp_b),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b)
  );

  assign better    = a_gt_b && !a_eq_b;
  assign o_valid   = fifo_valid;
  assign o_ready   = rdy_en && (has_room || (fifo_valid && i_ready));
  assign accept    = i_valid && o_ready && !i_flush;
  assign last_beat = (cnt_p0 == LAST);
  assign wr_pend   = accept && last_beat;
  assign cand_data = better ? i_data : best_p0;
  assign cand_idx  = better ? cnt_p0 : best_idx_p0;
  assign push_data = term_p0 ? {FP_ZERO[DATA_WIDTH-1:0], {INDEX_WIDTH{1'b0}}, 1'b1}
                             : {cand_data, cand_idx, 1'b0};

  // Stage p0: element counter and running best, updated on each accepted beat
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rdy_en <= 1'b0;
      cnt_p0 <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (i_flush)     cnt_p0 <= '0;
      else if (accept) cnt_p0 <= last_beat ? '0 : cnt_p0 + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (cnt_p0 == '0) begin
        best_p0     <= i_data;
        best_idx_p0 <= '0;
        term_p0     <= i_done;
      end else if (better) begin
        best_p0     <= i_data;
        best_idx_p0 <= cnt_p0;
      end
    end
  end

  // Stage p1: completed group result queued for the downstream loss stage
  target_q_result_fifo #(
    .WIDTH (FW),
    .DEPTH (RESULT_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst_n),
    .push      (wr_pend),
    .push_data (push_data),
    .pop       (i_ready),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .has_room  (has_room)
  );

  assign o_data     = fifo_valid ? fifo_head[FW-1 -: DATA_WIDTH]  : '0;
  assign o_index    = fifo_valid ? fifo_head[INDEX_WIDTH:1]       : '0;
  assign o_terminal = fifo_valid ? fifo_head[0]                   : 1'b0;

endmodule
